sub32_serial: RTL

Byte-serial 32-bit magnitude subtractor: accepts an operand pair over a valid/ready handshake and returns |a − b|, a swap flag (a < b) and a zero flag. It is the inverse-direction companion to the 8-bit CLA adder in the fp-adder32 datapath. It reuses one 8-bit adder slice over four cycles instead of a 32-bit subtractor, and feeds the exponent-difference and mantissa-subtract paths of the FP adder.

---
 rtl/sub32_serial_pkg.sv | 11 +
 rtl/sub32_serial_add8.sv | 20 ++
 rtl/sub32_serial.sv | 105 ++++++++++
 3 files changed

// File: rtl/sub32_serial_pkg.sv
// sub32_serial_pkg: shared state encoding and default parameters for the serial subtractor
package sub32_serial_pkg;
    localparam int  NBYTES_DEF = 4;
    localparam real T_DEF      = 0.0;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/sub32_serial_add8.sv
// sub32_serial_add8: 8-bit adder slice with carry-in and carry-out
//   a, b : 8-bit addends
//   ci   : carry in
//   s    : 8-bit sum
//   c7   : carry out of bit 7
module sub32_serial_add8 #(
    parameter real T = 0.0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       c7
);
    // T only shapes simulation timing; a negative delay is meaningless
    if (T < 0.0) begin : g_bad_t
        $error("add8: T must be non-negative");
    end
    assign {c7, s} = {1'b0, a} + {1'b0, b} + {8'b0, ci};
endmodule

// File: rtl/sub32_serial.sv
// sub32_serial: byte-serial unsigned magnitude subtractor returning |a-b|, swap (a<b) and zero (a==b)
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (ready only in IDLE)
//   a, b                 : W-bit unsigned minuend and subtrahend
//   out_valid, out_ready : result handshake (result held until accepted)
//   diff, swap, zero     : |a-b|, a<b flag, a==b flag
module sub32_serial
    import sub32_serial_pkg::*;
#(
    parameter real T      = T_DEF,
    parameter int  NBYTES = NBYTES_DEF,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         swap,
    output logic         zero
);
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    state_t        state;
    logic [W-1:0]  a_q, b_q, diff_nxt;
    logic [KW-1:0] k;
    logic          carry, c7, last;
    logic [7:0]    op_a, op_b, sum;
    // SUB computes a + ~b + 1; NEG computes ~diff + 1 to flip a negative result
    assign op_a     = (state == NEG) ? ~diff[k*8 +: 8] : a_q[k*8 +: 8];
    assign op_b     = (state == NEG) ? 8'h00 : ~b_q[k*8 +: 8];
    assign last     = (k == KW'(NBYTES - 1));
    assign in_ready = (state == IDLE) && !rst;
    sub32_serial_add8 #(.T(T)) u_add8 (
        .a  (op_a),
        .b  (op_b),
        .ci (carry),
        .s  (sum),
        .c7 (c7)
    );
    always_comb begin
        diff_nxt            = diff;
        diff_nxt[k*8 +: 8]  = sum;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            diff      <= '0;
            swap      <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    k     <= '0;
                    carry <= 1'b1;
                    swap  <= 1'b0;
                    zero  <= 1'b0;
                    state <= SUB;
                end
                SUB: begin
                    diff  <= diff_nxt;
                    carry <= c7;
                    k     <= last ? '0 : k + 1'b1;
                    if (last) begin
                        // final carry-out set means no borrow, i.e. a >= b
                        if (c7) begin
                            zero      <= (diff_nxt == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            swap  <= 1'b1;
                            carry <= 1'b1;
                            state <= NEG;
                        end
                    end
                end
                NEG: begin
                    diff  <= diff_nxt;
                    carry <= c7;
                    k     <= last ? '0 : k + 1'b1;
                    if (last) begin
                        zero      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
